// File: rtl/collision_pkg.sv
// Shared constants, sprite register field positions and scan FSM encoding
// for the collision unit.
package collision_pkg;

   localparam int BUS_DATA      = 32;
   localparam int SEL_BITS      = 5;
   localparam int MOBILE        = 15;
   localparam int TOTAL_SPRITES = 32;
   localparam int SPRITE_SIZE   = 20;

   localparam int ACTIVE_BIT = 29;
   localparam int X_MSB      = 28;
   localparam int X_LSB      = 19;
   localparam int Y_MSB      = 18;
   localparam int Y_LSB      = 9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_SCAN,
      ST_COMMIT
   } scan_state_t;

endpackage

// File: rtl/bbox_overlap.sv
// Combinational bounding-box overlap test between two sprite register words.
// Both sprites must be active; coordinate differences never wrap around.
module bbox_overlap
   import collision_pkg::*;
(
   input  logic [BUS_DATA-1:0] sprite_a,
   input  logic [BUS_DATA-1:0] sprite_b,
   output logic                overlap
);

   logic [10:0] xa, xb, ya, yb, dx, dy;
   logic        unused_bits;

   assign xa = {1'b0, sprite_a[X_MSB:X_LSB]};
   assign xb = {1'b0, sprite_b[X_MSB:X_LSB]};
   assign ya = {1'b0, sprite_a[Y_MSB:Y_LSB]};
   assign yb = {1'b0, sprite_b[Y_MSB:Y_LSB]};

   // Absolute differences: subtract the smaller operand from the larger one
   assign dx = (xa > xb) ? (xa - xb) : (xb - xa);
   assign dy = (ya > yb) ? (ya - yb) : (yb - ya);

   assign overlap = sprite_a[ACTIVE_BIT] & sprite_b[ACTIVE_BIT]
                  & (dx < 11'(SPRITE_SIZE)) & (dy < 11'(SPRITE_SIZE));

   assign unused_bits = ^{sprite_a[BUS_DATA-1:ACTIVE_BIT+1], sprite_a[Y_LSB-1:0],
                          sprite_b[BUS_DATA-1:ACTIVE_BIT+1], sprite_b[Y_LSB-1:0]};

endmodule

// File: rtl/collision_scan_ctrl.sv
// Walks the sprite bank through the external 32:1 mux, latching one reference
// sprite per mobile index and testing it against every later sprite.
module collision_scan_ctrl
   import collision_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [BUS_DATA-1:0] reg_data,
   output logic [SEL_BITS-1:0] selector,
   output logic                busy,
   output logic                done,
   output logic [MOBILE-1:0]   collision
);

   scan_state_t         state_q, state_d;
   logic [SEL_BITS-1:0] i_q, i_d;
   logic [SEL_BITS-1:0] j_q, j_d;
   logic [SEL_BITS-1:0] selector_q, selector_d;
   logic [BUS_DATA-1:0] ref_sprite_q, ref_sprite_d;
   logic [MOBILE-1:0]   work_q, work_d;
   logic [MOBILE-1:0]   collision_q, collision_d;
   logic                hit;
   logic                last_i, last_j;

   bbox_overlap u_overlap (
      .sprite_a (ref_sprite_q),
      .sprite_b (reg_data),
      .overlap  (hit)
   );

   assign last_i = (i_q == SEL_BITS'(MOBILE - 1));
   assign last_j = (j_q == SEL_BITS'(TOTAL_SPRITES - 1));

   // The selector is registered, so it is loaded with the index the next state will read
   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      j_d          = j_q;
      selector_d   = selector_q;
      ref_sprite_d = ref_sprite_q;
      work_d       = work_q;
      collision_d  = collision_q;

      case (state_q)
         ST_IDLE: begin
            selector_d = '0;
            if (start) begin
               state_d = ST_LOAD_A;
               work_d  = '0;
               i_d     = '0;
            end
         end
         ST_LOAD_A: begin
            ref_sprite_d = reg_data;
            j_d          = i_q + 1'b1;
            selector_d   = i_q + 1'b1;
            state_d      = ST_SCAN;
         end
         ST_SCAN: begin
            if (hit) begin
               work_d = work_q | (MOBILE'(1) << i_q);
               if (j_q < SEL_BITS'(MOBILE)) begin
                  work_d = work_d | (MOBILE'(1) << j_q);
               end
            end
            if (last_j && last_i) begin
               state_d     = ST_COMMIT;
               collision_d = work_d;
               selector_d  = '0;
            end else if (last_j) begin
               state_d    = ST_LOAD_A;
               i_d        = i_q + 1'b1;
               selector_d = i_q + 1'b1;
            end else begin
               j_d        = j_q + 1'b1;
               selector_d = j_q + 1'b1;
            end
         end
         ST_COMMIT: begin
            state_d    = ST_IDLE;
            selector_d = '0;
         end
         default: begin
            state_d    = ST_IDLE;
            selector_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         i_q          <= '0;
         j_q          <= '0;
         selector_q   <= '0;
         ref_sprite_q <= '0;
         work_q       <= '0;
         collision_q  <= '0;
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         j_q          <= j_d;
         selector_q   <= selector_d;
         ref_sprite_q <= ref_sprite_d;
         work_q       <= work_d;
         collision_q  <= collision_d;
      end
   end

   assign selector  = selector_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_COMMIT);
   assign collision = collision_q;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Self-checking bench for collision_scan_ctrl: a sprite bank model drives the
// mux input, and a cycle-level reference model is compared on every cycle.
module tb_collision_scan_ctrl;

   localparam int SCAN_LEN = 375;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] reg_data;
   logic [4:0]  selector;
   logic        busy;
   logic        done;
   logic [14:0] collision;

   logic [31:0] sprites [32];
   int          sel_tab [$];
   int          checks = 0;
   int          errors = 0;

   int          m_cnt  = 0;
   logic [14:0] m_coll = '0;
   logic [14:0] m_next = '0;

   collision_scan_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .reg_data  (reg_data),
      .selector  (selector),
      .busy      (busy),
      .done      (done),
      .collision (collision)
   );

   assign reg_data = sprites[selector];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Ignored register bits are filled with junk to prove the DUT disregards them
   task automatic place_sprite(input int idx, input int active, input int x, input int y);
      sprites[idx] = 32'h8000_0000 | (32'(active) << 29) | (32'(x) << 19) | (32'(y) << 9) | 32'h0000_00AA;
   endtask

   task automatic clear_sprites();
      for (int k = 0; k < 32; k++) place_sprite(k, 0, 0, 0);
   endtask

   // Reference flags straight from the pair rules, using integer coordinates
   function automatic logic [14:0] model_flags();
      logic [14:0] f;
      int xa, ya, xb, yb, dx, dy;
      f = '0;
      for (int a = 0; a < 15; a++) begin
         for (int b = a + 1; b < 32; b++) begin
            if (((sprites[a] >> 29) & 1) == 1 && ((sprites[b] >> 29) & 1) == 1) begin
               xa = int'((sprites[a] >> 19) & 32'h3FF);
               ya = int'((sprites[a] >> 9) & 32'h3FF);
               xb = int'((sprites[b] >> 19) & 32'h3FF);
               yb = int'((sprites[b] >> 9) & 32'h3FF);
               dx = (xa > xb) ? xa - xb : xb - xa;
               dy = (ya > yb) ? ya - yb : yb - ya;
               if (dx < 20 && dy < 20) begin
                  f[a] = 1'b1;
                  if (b < 15) f[b] = 1'b1;
               end
            end
         end
      end
      return f;
   endfunction

   // Cycle-level model: m_cnt is the position within a scan (0 = idle)
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt  = 0;
         m_coll = '0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt  = 1;
            m_next = model_flags();
         end
      end else if (m_cnt == SCAN_LEN + 1) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt == SCAN_LEN + 1) m_coll = m_next;
      end
   end

   always @(negedge clk) begin
      logic [4:0] e_sel;
      e_sel = (m_cnt >= 1 && m_cnt <= SCAN_LEN) ? 5'(sel_tab[m_cnt - 1]) : 5'd0;
      checkOutput("busy", 32'(busy), 32'(m_cnt != 0));
      checkOutput("done", 32'(done), 32'(m_cnt == SCAN_LEN + 1));
      checkOutput("selector", 32'(selector), 32'(e_sel));
      checkOutput("collision", 32'(collision), 32'(m_coll));
   end

   // Launches a scan and follows it to done; extra start pulses land at scan cycles x1..x3
   task automatic applyStimulus(input logic [14:0] exp_coll, input string name,
                                input int x1, input int x2, input int x3);
      int busy_cycles;
      int n;
      bit seen;
      @(negedge clk);
      start       = 1'b1;
      busy_cycles = 0;
      n           = 0;
      seen        = 1'b0;
      while (!seen && n < 500) begin
         @(negedge clk);
         n++;
         start = (n == x1) || (n == x2) || (n == x3);
         if (busy) busy_cycles++;
         if (done) seen = 1'b1;
      end
      if (start) begin
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
      checkOutput({name, "_latency"}, 32'(n), 32'd376);
      checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'd376);
      checkOutput({name, "_flags"}, 32'(collision), 32'(exp_coll));
   endtask

   initial begin
      for (int a = 0; a < 15; a++) begin
         sel_tab.push_back(a);
         for (int b = a + 1; b < 32; b++) sel_tab.push_back(b);
      end
      reset = 1'b0;
      start = 1'b0;
      clear_sprites();
      checkOutput("model_scan_len", 32'(sel_tab.size()), 32'd375);

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_selector", 32'(selector), 32'd0);
      checkOutput("reset_collision", 32'(collision), 32'd0);
      reset = 1'b1;

      applyStimulus(15'h0000, "all_inactive", 0, 0, 0);

      place_sprite(0, 1, 100, 100);
      place_sprite(20, 1, 119, 119);
      applyStimulus(15'h0001, "mobile_vs_fixed", 0, 0, 0);

      clear_sprites();
      place_sprite(3, 1, 50, 50);
      place_sprite(9, 1, 70, 50);
      applyStimulus(15'h0000, "distance_20", 0, 0, 0);
      place_sprite(9, 1, 69, 50);
      applyStimulus(15'h0208, "distance_19", 0, 0, 0);

      clear_sprites();
      place_sprite(15, 1, 300, 300);
      place_sprite(16, 1, 300, 300);
      applyStimulus(15'h0000, "fixed_fixed", 0, 0, 0);

      clear_sprites();
      place_sprite(1, 1, 1010, 40);
      place_sprite(2, 1, 5, 40);
      place_sprite(4, 1, 200, 300);
      place_sprite(12, 1, 200, 319);
      place_sprite(6, 0, 500, 500);
      place_sprite(7, 1, 500, 500);
      place_sprite(13, 1, 700, 700);
      place_sprite(30, 1, 700, 680);
      applyStimulus(15'h1010, "mixed", 0, 0, 0);
      checkOutput("model_mixed", 32'(model_flags()), 32'h0000_1010);

      applyStimulus(15'h1010, "extra_starts", 10, 200, 376);
      place_sprite(12, 0, 200, 319);
      applyStimulus(15'h0000, "back_to_back_a", 0, 0, 0);
      place_sprite(12, 1, 200, 319);
      applyStimulus(15'h1010, "back_to_back_b", 0, 0, 0);

      clear_sprites();
      place_sprite(0, 1, 100, 100);
      place_sprite(20, 1, 119, 119);
      applyStimulus(15'h0001, "pre_abort", 0, 0, 0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (149) @(negedge clk);
      checkOutput("mid_scan_flags_held", 32'(collision), 32'h0000_0001);
      #2 reset = 1'b0;
      #1;
      checkOutput("abort_collision", 32'(collision), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_selector", 32'(selector), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(15'h0001, "after_abort", 0, 0, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/collision_scan_ctrl.md
# collision_scan_ctrl

Sequencer for the collision unit. On each start request it walks the 32-entry sprite register bank through the shared 32:1 selection mux and latches one entry as the reference sprite. It then tests every later entry against that sprite for bounding-box overlap. It publishes one collision flag per mobile sprite, and the flags stay frozen between scans. It sits between the sprite register file/mux and the game-logic read-back path, and is triggered once per frame (e.g. at vertical blank).

## Interface
- `BUS_DATA`, 32, sprite register width
- `SEL_BITS`, 5, mux selector width
- `MOBILE`, 15, number of mobile sprites (indices 0..MOBILE-1); indices MOBILE..31 are fixed sprites
- `SPRITE_SIZE`, 20, sprite edge length in pixels
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle scan request; ignored while `busy`
- `reg_data` in BUS_DATA: selected sprite register, returned combinationally by the mux in the same cycle
- `selector` out SEL_BITS: mux select, registered
- `busy` out 1: scan in progress
- `done` out 1: one-cycle pulse when the flags are committed
- `collision` out MOBILE: bit k = mobile sprite k overlapped any active sprite during the last completed scan

## Operation
- Sprite register fields: bit 29 = active; [28:19] = x (10 b unsigned); [18:9] = y (10 b unsigned); other bits are ignored.
- Overlap test: |xa−xb| < SPRITE_SIZE and |ya−yb| < SPRITE_SIZE.
  - Differences are computed in 11 bits; no wrap-around.
  - The test counts only when both sprites are active.
- Pair order:
  - Outer index i runs 0..MOBILE-1.
  - Inner index j runs i+1..31.
  - Fixed–fixed pairs are never tested. A sprite is never tested against itself.
- On an overlapping pair: set work[i]; also set work[j] if j < MOBILE.
- `work` is an internal MOBILE-bit accumulator, cleared on scan start.
- FSM states and transitions:
  - IDLE: selector=0, busy=0. `start` → LOAD_A; work cleared, i=0.
  - LOAD_A: selector=i; latch reg_data into ref register; j=i+1 → SCAN.
  - SCAN: selector=j; compare ref against reg_data and update work.
    - j==31 and i==MOBILE-1 → COMMIT.
    - j==31 otherwise → LOAD_A with i+1.
    - Else j+1.
  - COMMIT: collision ← work; done=1 → IDLE.
- An inactive reference sprite is still walked (fixed cycle count); it produces no hits.
- `start` in any state other than IDLE is dropped, not queued.
- Reset values:
  - selector=0, busy=0, done=0, collision=0, state=IDLE.
  - Internal i, j, ref and work also reset to 0.
- Reset mid-scan: abort immediately; collision=0 (the previous result is discarded).

## Timing
- `start` sampled high at edge 0 → busy=1 from edge 1 (LOAD_A, i=0).
- Scan length = Σ_{i=0}^{14}(1 + 31 − i) = 375 cycles (LOAD_A plus SCAN).
- COMMIT occupies cycle 376: done=1 and collision updated at that edge; busy=0 and back in IDLE at edge 377.
- `busy` is high for exactly 376 cycles (375 scan cycles plus COMMIT).
- Start-to-done latency: 376 cycles. Minimum start-to-start interval: 377 cycles.
- `collision` changes only at the COMMIT edge or on reset; it is stable for the full inter-scan interval.
- Mux path: selector is registered, mux and comparator are combinational; one pair is evaluated per cycle.

## Structure
- Shared package (`collision_pkg`):
  - Field positions ACTIVE_BIT, X_MSB/LSB and Y_MSB/LSB.
  - SPRITE_SIZE, MOBILE and TOTAL_SPRITES=32.
  - FSM state encoding.
- One sub-module is natural: `bbox_overlap`, a combinational two-sprite comparator (two register words in, overlap bit out). It can be reused by a future per-pair query port.
- The controller drives the existing 32:1 mux; the mux is not instantiated inside this block.

## Test plan
- All sprites inactive, start → done after 376 cycles, collision=15'h0000, busy high exactly 376 cycles.
- Sprite 0 active at (100,100), fixed sprite 20 active at (119,119), others inactive → collision=15'h0001.
- Sprite 3 at (50,50) and sprite 9 at (70,50) (distance 20, not overlapping) → collision=0; move sprite 9 to (69,50) and rescan → collision=15'h0208.
- Fixed sprites 15 and 16 overlap at the same position, mobiles inactive → collision=0 (fixed–fixed pair skipped).
- A second start pulse at cycles 10 and 200 of a scan → ignored; a single done at cycle 376; a start right after done launches a new scan.
- Reset asserted at cycle 150 of a scan with a prior result of 15'h0001 → collision=0, busy=0, selector=0 immediately; the next start produces a full 376-cycle scan.
